// File: rtl/sram_pixel_fetch_if.sv
// sram_pixel_fetch_if: SRAM read bus, pixel stream and control bundle for sram_pixel_fetch
interface sram_pixel_fetch_if #(parameter int ADDR_W = 32);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              read_req;
  logic [ADDR_W-1:0] read_addr;
  logic [31:0]       read_data;
  logic              read_valid;
  logic [7:0]        pix_out;
  logic              pix_valid;
  logic              pix_ready;
  logic              row_end;
  logic              img_done;
  logic              busy;
  modport master (
    input  start, base_addr, read_data, read_valid, pix_ready,
    output read_req, read_addr, pix_out, pix_valid, row_end, img_done, busy
  );
  modport slave (
    output start, base_addr, read_data, read_valid, pix_ready,
    input  read_req, read_addr, pix_out, pix_valid, row_end, img_done, busy
  );
endinterface

// File: rtl/sram_pixel_fetch.sv
// sram_pixel_fetch: fetches packed 8-bit pixels from SRAM via a 2-word FIFO into a pixel stream
// SERPENTINE_READ_EN: odd rows fetched right-to-left (words WPR-1..0, bytes 3..0)
module sram_pixel_fetch #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 32
) (
  input logic               clk,
  input logic               rst,
  sram_pixel_fetch_if.master bus
);
  localparam int WPR = IMG_WIDTH / 4;
  localparam int WW  = $clog2(WPR + 1);
  localparam int RW  = $clog2(IMG_HEIGHT + 1);
  localparam logic [WW-1:0] WLAST = WW'(WPR - 1);
  localparam logic [RW-1:0] RLAST = RW'(IMG_HEIGHT - 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base;
  logic [RW-1:0] f_row, o_row;
  logic [WW-1:0] f_word, o_word, f_idx;
  logic [1:0] o_byte, b_idx, cnt, cnt_n;
  logic f_more, outst, wr_ptr, rd_ptr;
  logic [31:0] mem [2];
  logic push, pop, xfer, last_pix, can_fetch;
  assign push      = bus.read_valid & outst;
  assign xfer      = bus.pix_valid & bus.pix_ready;
  assign pop       = xfer & (o_byte == 2'd3);
  assign cnt_n     = cnt + {1'b0, push} - {1'b0, pop};
  assign can_fetch = f_more & (cnt_n != 2'd2);
  assign last_pix  = pop & (o_word == WLAST) & (o_row == RLAST);
`ifdef SERPENTINE_READ_EN
  assign f_idx = f_row[0] ? WLAST - f_word : f_word;
  assign b_idx = o_row[0] ? ~o_byte : o_byte;
`else
  assign f_idx = f_word;
  assign b_idx = o_byte;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.start ? FETCH : IDLE;
      FETCH:   state_n = WAIT;
      WAIT:    state_n = !push ? WAIT : can_fetch ? FETCH : DRAIN;
      DRAIN:   state_n = can_fetch ? FETCH : last_pix ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.read_req  = state == FETCH;
  assign bus.read_addr = bus.read_req ? base + ((ADDR_W'(f_row) * ADDR_W'(WPR) + ADDR_W'(f_idx)) << 2) : '0;
  assign bus.busy      = state != IDLE;
  assign bus.img_done  = state == DONE;
  assign bus.pix_valid = cnt != 2'd0;
  assign bus.pix_out   = mem[rd_ptr][{b_idx, 3'b000} +: 8];
  assign bus.row_end   = bus.pix_valid & (o_byte == 2'd3) & (o_word == WLAST);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      base   <= '0;
      f_row  <= '0;
      f_word <= '0;
      f_more <= 1'b0;
      outst  <= 1'b0;
      o_row  <= '0;
      o_word <= '0;
      o_byte <= '0;
      cnt    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      outst <= bus.read_req | (outst & !bus.read_valid);
      if (state == IDLE && bus.start) begin
        base   <= bus.base_addr;
        f_row  <= '0;
        f_word <= '0;
        f_more <= 1'b1;
        o_row  <= '0;
        o_word <= '0;
        o_byte <= '0;
      end
      if (bus.read_req) begin
        f_word <= (f_word == WLAST) ? '0 : f_word + 1'b1;
        if (f_word == WLAST) begin
          f_row  <= f_row + 1'b1;
          f_more <= f_row != RLAST;
        end
      end
      if (push) begin
        mem[wr_ptr] <= bus.read_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (xfer) o_byte <= o_byte + 1'b1;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        o_word <= (o_word == WLAST) ? '0 : o_word + 1'b1;
        if (o_word == WLAST) o_row <= o_row + 1'b1;
      end
    end
  end
endmodule
